// File: rtl/melody_sequencer_pkg.sv
// rtl/melody_sequencer_pkg.sv - shared types, pitch constants and pitch mapping for the melody sequencer
// Purpose: pitch half-period constants M1..M7, pitch-code enum, score-entry
//          struct, sequencer state enum and the pitch-to-period function.
// Ports:   none (package).
package melody_sequencer_pkg;

  localparam logic [16:0] M1 = 17'd95600;
  localparam logic [16:0] M2 = 17'd85150;
  localparam logic [16:0] M3 = 17'd75850;
  localparam logic [16:0] M4 = 17'd71600;
  localparam logic [16:0] M5 = 17'd63750;
  localparam logic [16:0] M6 = 17'd56800;
  localparam logic [16:0] M7 = 17'd50600;

  typedef enum logic [3:0] {
    REST = 4'd0,
    DO   = 4'd1,
    RE   = 4'd2,
    MI   = 4'd3,
    FA   = 4'd4,
    SO   = 4'd5,
    LA   = 4'd6,
    SI   = 4'd7
  } pitch_e;

  typedef struct packed {
    logic [3:0] pitch;
    logic [1:0] dur;
  } score_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_e;

  // Codes 0 and 8..15 are rests and map to a zero (silent) period.
  function automatic logic [16:0] pitch_period(input logic [3:0] pitch);
    case (pitch)
      4'd1:    return M1;
      4'd2:    return M2;
      4'd3:    return M3;
      4'd4:    return M4;
      4'd5:    return M5;
      4'd6:    return M6;
      4'd7:    return M7;
      default: return 17'd0;
    endcase
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// rtl/melody_sequencer_if.sv - control and note bus between sequencer and its user
// Purpose: groups the playback controls and the note outputs.
// Ports:   start/stop (pulses), pause (level) from master;
//          note_period, tone_en, note_idx, busy, done from slave.
interface melody_sequencer_if;

  logic        start;
  logic        stop;
  logic        pause;
  logic [16:0] note_period;
  logic        tone_en;
  logic [4:0]  note_idx;
  logic        busy;
  logic        done;

  modport master (
    output start, stop, pause,
    input  note_period, tone_en, note_idx, busy, done
  );

  modport slave (
    input  start, stop, pause,
    output note_period, tone_en, note_idx, busy, done
  );

endinterface

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - 32x6 synchronous score ROM
// Purpose: holds the fixed score; one-cycle read latency.
// Ports:   clk, i_addr (entry index), o_entry (registered {pitch, dur}).
module melody_rom
  import melody_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic [4:0]   i_addr,
  output score_entry_t o_entry
);

  function automatic score_entry_t mk(input pitch_e p, input logic [1:0] d);
    score_entry_t e;
    e.pitch = p;
    e.dur   = d;
    return e;
  endfunction

  function automatic score_entry_t entry_at(input logic [4:0] a);
    case (a)
      5'd0:    return mk(DO,   2'd0);
      5'd1:    return mk(RE,   2'd0);
      5'd2:    return mk(MI,   2'd1);
      5'd3:    return mk(REST, 2'd0);
      5'd4:    return mk(DO,   2'd0);
      5'd5:    return mk(DO,   2'd0);
      5'd6:    return mk(SO,   2'd0);
      5'd7:    return mk(SO,   2'd0);
      5'd8:    return mk(LA,   2'd0);
      5'd9:    return mk(LA,   2'd0);
      5'd10:   return mk(SO,   2'd1);
      5'd11:   return mk(FA,   2'd0);
      5'd12:   return mk(FA,   2'd0);
      5'd13:   return mk(MI,   2'd0);
      5'd14:   return mk(MI,   2'd0);
      5'd15:   return mk(RE,   2'd0);
      5'd16:   return mk(RE,   2'd0);
      5'd17:   return mk(DO,   2'd1);
      5'd18:   return mk(SO,   2'd0);
      5'd19:   return mk(SO,   2'd0);
      5'd20:   return mk(FA,   2'd0);
      5'd21:   return mk(FA,   2'd0);
      5'd22:   return mk(MI,   2'd0);
      5'd23:   return mk(MI,   2'd0);
      5'd24:   return mk(RE,   2'd1);
      5'd25:   return mk(SO,   2'd0);
      5'd26:   return mk(SO,   2'd0);
      5'd27:   return mk(FA,   2'd0);
      5'd28:   return mk(FA,   2'd0);
      5'd29:   return mk(MI,   2'd0);
      5'd30:   return mk(RE,   2'd1);
      default: return mk(REST, 2'd3);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    o_entry <= entry_at(i_addr);
  end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - score walker feeding the buzzer PWM stage
// Purpose: plays score entries at a programmable tempo with a silent
//          articulation gap at the end of each note; start/stop/pause control.
// Ports:   clk, rst_n (async active-low);
//          bus.start/stop/pause in; bus.note_period/tone_en/note_idx/busy/done out.
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 500000,
  parameter int SCORE_LEN   = 32,
  parameter bit LOOP        = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  melody_sequencer_if.slave bus
);

  localparam logic [4:0]  LAST_IDX = 5'(SCORE_LEN - 1);
  localparam logic [25:0] GAP_LAST = 26'(GAP_CYCLES - 1);

  state_e       r_state, w_state_next;
  logic [4:0]   r_idx, w_idx_next;
  logic [16:0]  r_period, w_period_next;
  logic [1:0]   r_dur, w_dur_next;
  logic [25:0]  r_cnt, w_cnt_next;
  logic [25:0]  w_play_last;
  score_entry_t w_rom_entry;

  // The ROM is addressed with the next index so its registered output is
  // already valid during the single LOAD cycle that follows.
  melody_rom u_rom (
    .clk     (clk),
    .i_addr  (w_idx_next),
    .o_entry (w_rom_entry)
  );

  // Sounding part of a note: full length minus the trailing gap.
  assign w_play_last = 26'((int'(r_dur) + 1) * BEAT_CYCLES - GAP_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= 5'd0;
      r_period <= 17'd0;
      r_dur    <= 2'd0;
      r_cnt    <= 26'd0;
    end else begin
      r_state  <= w_state_next;
      r_idx    <= w_idx_next;
      r_period <= w_period_next;
      r_dur    <= w_dur_next;
      r_cnt    <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_period_next = r_period;
    w_dur_next    = r_dur;
    w_cnt_next    = r_cnt;

    if (bus.stop) begin
      // stop overrides start and pause in every state
      w_state_next  = ST_IDLE;
      w_idx_next    = 5'd0;
      w_period_next = 17'd0;
      w_cnt_next    = 26'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            w_state_next = ST_LOAD;
            w_idx_next   = 5'd0;
            w_cnt_next   = 26'd0;
          end
        end
        ST_LOAD: begin
          w_period_next = pitch_period(w_rom_entry.pitch);
          w_dur_next    = w_rom_entry.dur;
          w_cnt_next    = 26'd0;
          w_state_next  = ST_PLAY;
        end
        ST_PLAY: begin
          if (!bus.pause) begin
            if (r_cnt == w_play_last) begin
              w_cnt_next   = 26'd0;
              w_state_next = ST_GAP;
            end else begin
              w_cnt_next = r_cnt + 26'd1;
            end
          end
        end
        ST_GAP: begin
          if (!bus.pause) begin
            if (r_cnt == GAP_LAST) begin
              w_cnt_next = 26'd0;
              if (r_idx != LAST_IDX) begin
                w_idx_next   = r_idx + 5'd1;
                w_state_next = ST_LOAD;
              end else if (LOOP) begin
                w_idx_next   = 5'd0;
                w_state_next = ST_LOAD;
              end else begin
                w_state_next = ST_DONE;
              end
            end else begin
              w_cnt_next = r_cnt + 26'd1;
            end
          end
        end
        ST_DONE: begin
          w_state_next  = ST_IDLE;
          w_idx_next    = 5'd0;
          w_period_next = 17'd0;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // pause silences the tone immediately; the period is left untouched.
  assign bus.tone_en     = (r_state == ST_PLAY) && !bus.pause && (r_period != 17'd0);
  assign bus.note_period = r_period;
  assign bus.note_idx    = r_idx;
  assign bus.busy        = (r_state == ST_LOAD) || (r_state == ST_PLAY) || (r_state == ST_GAP);
  assign bus.done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - scoreboard bench for melody_sequencer (LOOP=0 and LOOP=1 instances)
module tb_melody_sequencer;

  localparam int BEAT = 10;
  localparam int GAP  = 2;
  localparam int LEN  = 4;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_PLAY = 2;
  localparam int S_GAP  = 3;
  localparam int S_DONE = 4;

  typedef struct packed {
    logic        tone;
    logic [16:0] per;
    logic [4:0]  idx;
    logic        busy;
    logic        done;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  melody_sequencer_if bus0 ();
  melody_sequencer_if bus1 ();

  melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SCORE_LEN(LEN), .LOOP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SCORE_LEN(LEN), .LOOP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int total = 0;
  int bad = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  obs_t q0[$];
  obs_t q1[$];

  // Reference model: notes described by remaining-cycle counts.
  int score_pitch[LEN] = '{1, 2, 3, 0};
  int score_dur[LEN]   = '{0, 0, 1, 0};
  int m_mode[2];
  int m_idx[2];
  int m_per[2];
  int m_rem[2];

  function automatic int period_of(int p);
    case (p)
      1: return 95600;
      2: return 85150;
      3: return 75850;
      4: return 71600;
      5: return 63750;
      6: return 56800;
      7: return 50600;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset(int d);
    m_mode[d] = S_IDLE;
    m_idx[d]  = 0;
    m_per[d]  = 0;
    m_rem[d]  = 0;
  endfunction

  function automatic obs_t model_out(int d, bit pa);
    obs_t o;
    o.tone = (m_mode[d] == S_PLAY) && !pa && (m_per[d] != 0);
    o.per  = 17'(m_per[d]);
    o.idx  = 5'(m_idx[d]);
    o.busy = (m_mode[d] == S_LOAD) || (m_mode[d] == S_PLAY) || (m_mode[d] == S_GAP);
    o.done = (m_mode[d] == S_DONE);
    return o;
  endfunction

  function automatic void model_step(int d, bit st, bit sp, bit pa);
    bit loop_en;
    loop_en = (d == 1);
    if (sp) begin
      m_mode[d] = S_IDLE;
      m_idx[d]  = 0;
      m_per[d]  = 0;
      return;
    end
    case (m_mode[d])
      S_IDLE: if (st) begin
        m_mode[d] = S_LOAD;
        m_idx[d]  = 0;
      end
      S_LOAD: begin
        m_per[d]  = period_of(score_pitch[m_idx[d]]);
        m_rem[d]  = (score_dur[m_idx[d]] + 1) * BEAT - GAP;
        m_mode[d] = S_PLAY;
      end
      S_PLAY: if (!pa) begin
        m_rem[d] = m_rem[d] - 1;
        if (m_rem[d] == 0) begin
          m_mode[d] = S_GAP;
          m_rem[d]  = GAP;
        end
      end
      S_GAP: if (!pa) begin
        m_rem[d] = m_rem[d] - 1;
        if (m_rem[d] == 0) begin
          if (m_idx[d] < LEN - 1) begin
            m_idx[d]  = m_idx[d] + 1;
            m_mode[d] = S_LOAD;
          end else if (loop_en) begin
            m_idx[d]  = 0;
            m_mode[d] = S_LOAD;
          end else begin
            m_mode[d] = S_DONE;
          end
        end
      end
      default: begin
        m_mode[d] = S_IDLE;
        m_idx[d]  = 0;
        m_per[d]  = 0;
      end
    endcase
  endfunction

  function automatic void check_obs(string name, obs_t act, obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got tone=%0b per=%0d idx=%0d busy=%0b done=%0b, want tone=%0b per=%0d idx=%0d busy=%0b done=%0b",
               name, act.tone, act.per, act.idx, act.busy, act.done,
               exp.tone, exp.per, exp.idx, exp.busy, exp.done);
    end
  endfunction

  function automatic void check_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endfunction

  function automatic obs_t sample0();
    obs_t o;
    o = {bus0.tone_en, bus0.note_period, bus0.note_idx, bus0.busy, bus0.done};
    return o;
  endfunction

  function automatic obs_t sample1();
    obs_t o;
    o = {bus1.tone_en, bus1.note_period, bus1.note_idx, bus1.busy, bus1.done};
    return o;
  endfunction

  // Monitor: compares whatever the DUTs present against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus0.done) done_cnt0++;
      if (bus1.done) done_cnt1++;
      if (q0.size() > 0) check_obs("dut0_cycle", sample0(), q0.pop_front());
      if (q1.size() > 0) check_obs("dut1_cycle", sample1(), q1.pop_front());
    end
  end

  // One clock of stimulus: drive inputs, queue expected outputs, advance model.
  task automatic cycle(bit st, bit sp, bit pa);
    @(posedge clk);
    #1;
    bus0.start = st; bus0.stop = sp; bus0.pause = pa;
    bus1.start = st; bus1.stop = sp; bus1.pause = pa;
    q0.push_back(model_out(0, pa));
    q1.push_back(model_out(1, pa));
    model_step(0, st, sp, pa);
    model_step(1, st, sp, pa);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    obs_t zero;
    bit   pa;
    zero = '0;
    bus0.start = 1'b0; bus0.stop = 1'b0; bus0.pause = 1'b0;
    bus1.start = 1'b0; bus1.stop = 1'b0; bus1.pause = 1'b0;
    model_reset(0);
    model_reset(1);

    #22;
    check_obs("reset_dut0", sample0(), zero);
    check_obs("reset_dut1", sample1(), zero);
    @(negedge clk);
    rst_n = 1'b1;

    // full score: LOOP=0 finishes with one done, LOOP=1 wraps
    idle(3);
    cycle(1'b1, 1'b0, 1'b0);
    idle(70);
    @(negedge clk);
    #1;
    check_int("done_pulses_noloop", done_cnt0, 1);
    check_int("done_pulses_loop", done_cnt1, 0);
    cycle(1'b0, 1'b1, 1'b0);
    idle(3);

    // pause for 5 cycles starting at the 4th PLAY cycle of entry 0
    cycle(1'b1, 1'b0, 1'b0);
    idle(4);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
    idle(40);
    cycle(1'b0, 1'b1, 1'b0);
    idle(3);

    // start and stop together from IDLE, also with pause
    cycle(1'b1, 1'b1, 1'b0);
    idle(3);
    cycle(1'b1, 1'b1, 1'b1);
    idle(3);

    // stop inside the gap of entry 1, then replay from entry 0
    cycle(1'b1, 1'b0, 1'b0);
    idle(21);
    cycle(1'b0, 1'b1, 1'b0);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0);
    idle(15);
    cycle(1'b0, 1'b1, 1'b0);
    idle(2);

    // start while busy is ignored
    cycle(1'b1, 1'b0, 1'b0);
    idle(6);
    cycle(1'b1, 1'b0, 1'b0);
    idle(30);
    cycle(1'b0, 1'b1, 1'b0);
    idle(2);

    // randomized control traffic
    pa = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) pa = ~pa;
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0, pa);
    end
    cycle(1'b0, 1'b1, 1'b0);
    idle(2);

    // asynchronous reset in the middle of a note
    cycle(1'b1, 1'b0, 1'b0);
    idle(5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus0.start = 1'b0; bus0.pause = 1'b0; bus0.stop = 1'b0;
    bus1.start = 1'b0; bus1.pause = 1'b0; bus1.stop = 1'b0;
    #1;
    check_obs("async_reset_dut0", sample0(), zero);
    check_obs("async_reset_dut1", sample1(), zero);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset(0);
    model_reset(1);
    idle(10);
    cycle(1'b1, 1'b0, 1'b0);
    idle(20);

    @(negedge clk);
    #1;
    check_int("queue0_drained", q0.size(), 0);
    check_int("queue1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
